// File: rtl/button_event_arbiter.sv
// Collects one-cycle press pulses from NUM_BTN detectors and serves them one at a time,
// in round-robin order, over a valid/ready event port with per-button overflow and lockout.
module button_event_arbiter #(
  parameter int NUM_BTN = 4,
  parameter int LOCKOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BTN-1:0]         press,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(NUM_BTN)-1:0] evt_id,
  output logic [NUM_BTN-1:0]         ovf,
  input  logic                       ovf_clr
);

  localparam int ID_W  = $clog2(NUM_BTN);
  localparam int CNT_W = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t             state_r, state_nx_s;
  logic [NUM_BTN-1:0] pending_r, ovf_r;
  logic [NUM_BTN-1:0] lock_mask_s, press_eff_s, clear_s, pending_nx_s, ovf_nx_s;
  logic [ID_W-1:0]    evt_id_r, rr_ptr_r, last_id_r, sel_id_s, rr_ptr_nx_s;
  logic [CNT_W-1:0]   lock_cnt_r, lock_cnt_nx_s;
  logic               sel_found_s, grant_s, handshake_s;

  // Index arithmetic modulo NUM_BTN, valid for non-power-of-two channel counts.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_BTN) begin
      sum = sum - NUM_BTN;
    end else begin
      sum = sum;
    end
    return sum[ID_W-1:0];
  endfunction

  // Round-robin search: first pending bit at or after rr_ptr, wrapping.
  always_comb begin
    sel_found_s = 1'b0;
    sel_id_s    = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      if (!sel_found_s && pending_r[wrap_add(rr_ptr_r, k)]) begin
        sel_found_s = 1'b1;
        sel_id_s    = wrap_add(rr_ptr_r, k);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // FSM next state together with the grant/handshake strobes it produces.
  always_comb begin
    state_nx_s  = state_r;
    grant_s     = 1'b0;
    handshake_s = 1'b0;
    clear_s     = '0;
    rr_ptr_nx_s = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (sel_found_s) begin
          state_nx_s        = OFFER;
          grant_s           = 1'b1;
          clear_s[sel_id_s] = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          state_nx_s  = IDLE;
          handshake_s = 1'b1;
          rr_ptr_nx_s = wrap_add(evt_id_r, 1);
        end else begin
          state_nx_s = OFFER;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Lockout masking, pending/overflow update and lockout counter next value.
  always_comb begin
    lock_mask_s = '0;
    if (lock_cnt_r != '0) begin
      lock_mask_s[last_id_r] = 1'b1;
    end else begin
      lock_mask_s = '0;
    end
    press_eff_s  = press & ~lock_mask_s;
    // A press landing on the bit being granted this cycle is a fresh event, not an overflow.
    pending_nx_s = (pending_r & ~clear_s) | press_eff_s;
    if (ovf_clr) begin
      ovf_nx_s = press_eff_s & pending_r & ~clear_s;
    end else begin
      ovf_nx_s = ovf_r | (press_eff_s & pending_r & ~clear_s);
    end
    if (handshake_s) begin
      lock_cnt_nx_s = CNT_W'(LOCKOUT);
    end else if (lock_cnt_r != '0) begin
      lock_cnt_nx_s = lock_cnt_r - CNT_W'(1);
    end else begin
      lock_cnt_nx_s = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath registers: pending, overflow, round-robin pointer, offered id and lockout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r  <= '0;
      ovf_r      <= '0;
      rr_ptr_r   <= '0;
      evt_id_r   <= '0;
      last_id_r  <= '0;
      lock_cnt_r <= '0;
    end else begin
      pending_r  <= pending_nx_s;
      ovf_r      <= ovf_nx_s;
      rr_ptr_r   <= rr_ptr_nx_s;
      lock_cnt_r <= lock_cnt_nx_s;
      if (grant_s) begin
        evt_id_r <= sel_id_s;
      end else begin
        evt_id_r <= evt_id_r;
      end
      if (handshake_s) begin
        last_id_r <= evt_id_r;
      end else begin
        last_id_r <= last_id_r;
      end
    end
  end

  assign evt_valid = (state_r == OFFER);
  assign evt_id    = evt_id_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed scenarios plus random traffic for button_event_arbiter (NUM_BTN=4, LOCKOUT=8),
// checked every cycle against a behavioural model built from integer arrays.
module tb_button_event_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] press;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [3:0] ovf;
  logic       ovf_clr;

  int total = 0;
  int bad   = 0;

  int m_pend[4];
  int m_ovf[4];
  int m_rr, m_offer, m_id, m_lock, m_last;

  int   ev_q[$];
  logic prev_v;

  button_event_arbiter #(.NUM_BTN(4), .LOCKOUT(8)) dut (
    .clk(clk), .reset(reset), .press(press), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_id(evt_id), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_ovf_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (m_ovf[i] != 0);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0;
      m_ovf[i]  = 0;
    end
    m_rr = 0; m_offer = 0; m_id = 0; m_lock = 0; m_last = 0;
  endtask

  // One clock edge of the arbiter's rules, given the inputs present at that edge.
  task automatic model_edge(input logic [3:0] p, input logic r, input logic c);
    int sel, locked;
    int np[4];
    int no[4];
    sel    = -1;
    locked = (m_lock > 0) ? m_last : -1;
    if (m_offer == 0) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_rr + k) % 4;
        if (sel < 0 && m_pend[j] != 0) sel = j;
      end
    end
    for (int i = 0; i < 4; i++) begin
      bit hit, keep;
      hit   = p[i] && (i != locked);
      keep  = (m_pend[i] != 0) && (i != sel);
      np[i] = (keep || hit) ? 1 : 0;
      no[i] = c ? 0 : m_ovf[i];
      if (hit && keep) no[i] = 1;
    end
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = np[i];
      m_ovf[i]  = no[i];
    end
    if (m_offer != 0 && r) begin
      m_offer = 0;
      m_rr    = (m_id + 1) % 4;
      m_last  = m_id;
      m_lock  = 8;
    end else begin
      if (m_lock > 0) m_lock--;
      if (sel >= 0) begin
        m_offer = 1;
        m_id    = sel;
      end
    end
  endtask

  task automatic step(input logic [3:0] p, input logic r, input logic c);
    press = p; evt_ready = r; ovf_clr = c;
    @(posedge clk);
    model_edge(p, r, c);
    #2;
    chk("evt_valid", 32'(evt_valid), 32'(m_offer));
    chk("evt_id", 32'(evt_id), 32'(m_id));
    chk("ovf", 32'(ovf), 32'(m_ovf_vec()));
    if (evt_valid && !prev_v) ev_q.push_back(int'(evt_id));
    prev_v = evt_valid;
  endtask

  task automatic do_reset();
    press = 4'b0000; evt_ready = 1'b0; ovf_clr = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_id", 32'(evt_id), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #2;
    reset  = 1'b0;
    prev_v = 1'b0;
    ev_q.delete();
  endtask

  task automatic chk_events(input string tag, input int n, input int e0, input int e1, input int e2);
    int exp_e[3];
    exp_e = '{e0, e1, e2};
    chk({tag, "_count"}, 32'(ev_q.size()), 32'(n));
    for (int k = 0; k < n; k++)
      chk({tag, "_id"}, (k < ev_q.size()) ? 32'(ev_q[k]) : 32'hFFFF_FFFF, 32'(exp_e[k]));
  endtask

  initial begin
    reset = 1'b1; press = 4'b0000; evt_ready = 1'b0; ovf_clr = 1'b0; prev_v = 1'b0;
    do_reset();

    // Single press: offered two edges after the press, then exactly one event.
    step(4'b0010, 1'b1, 1'b0);
    chk("single_t1_valid", 32'(evt_valid), 32'd0);
    step(4'b0000, 1'b1, 1'b0);
    chk("single_t2_valid", 32'(evt_valid), 32'd1);
    chk("single_t2_id", 32'(evt_id), 32'd1);
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b1, 1'b0);
    chk_events("single", 1, 1, 0, 0);
    // rr_ptr is now 2: buttons 0 and 3 together must be served 3 first.
    step(4'b1001, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(4'b0000, 1'b1, 1'b0);
    chk_events("rrptr", 3, 1, 3, 0);

    // All four at once from reset: 0,1,2,3 with an idle cycle between each.
    do_reset();
    step(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0);
    chk_events("rr_half", 2, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b1, 1'b0);
    chk("rr_valid_end", 32'(evt_valid), 32'd0);
    chk("rr_ovf", 32'(ovf), 32'd0);
    if (ev_q.size() == 4) begin
      chk("rr_id2", 32'(ev_q[2]), 32'd2);
      chk("rr_id3", 32'(ev_q[3]), 32'd3);
    end else begin
      chk("rr_count", 32'(ev_q.size()), 32'd4);
    end

    // Backpressure and overflow on button 2, then ovf_clr.
    do_reset();
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    chk("bp_held_id", 32'(evt_id), 32'd2);
    chk("bp_held_valid", 32'(evt_valid), 32'd1);
    chk("bp_ovf", 32'(ovf), 32'b0100);
    for (int i = 0; i < 8; i++) step(4'b0000, 1'b1, 1'b0);
    chk_events("bp", 3, 2, 0, 2);
    // ovf_clr coinciding with a fresh overflow on button 1: the overflow wins.
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b1);
    chk("clr_vs_ovf", 32'(ovf), 32'b0010);
    step(4'b0000, 1'b1, 1'b1);
    chk("clr_done", 32'(ovf), 32'b0000);
    for (int i = 0; i < 6; i++) step(4'b0000, 1'b1, 1'b0);

    // Lockout of button 3 after its handshake.
    do_reset();
    step(4'b1000, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b1010, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(4'b0000, 1'b1, 1'b0);
    chk_events("lock", 3, 3, 1, 3);
    chk("lock_ovf", 32'(ovf), 32'd0);

    // Asynchronous reset in the middle of an offer with another event pending.
    do_reset();
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    chk("ar_pre_valid", 32'(evt_valid), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(evt_valid), 32'd0);
    chk("ar_id", 32'(evt_id), 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0; prev_v = 1'b0; ev_q.delete();
    for (int i = 0; i < 6; i++) step(4'b0000, 1'b1, 1'b0);
    chk("ar_no_event", 32'(ev_q.size()), 32'd0);

    // Press arriving the same cycle its pending bit is granted.
    do_reset();
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b1, 1'b0);
    chk_events("coinc", 2, 2, 2, 0);
    chk("coinc_ovf", 32'(ovf), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [3:0] p;
      p = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      step(p, ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 SHALL have parameter NUM_BTN, default 4: number of pushbutton detector channels served (2..8).
REQ-002 SHALL have parameter LOCKOUT, default 16: cycles during which the last-granted button's presses are ignored after its handshake (0 = disabled).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port press  input  NUM_BTN  one-cycle press pulses, one bit per pushbutton detector output.
REQ-006 SHALL have port evt_valid  output  1  event offered to consumer.
REQ-007 SHALL have port evt_ready  input  1  consumer accepts event.
REQ-008 SHALL have port evt_id  output  clog2(NUM_BTN)  index of button whose event is offered.
REQ-009 SHALL have port ovf  output  NUM_BTN  sticky per-button overflow flags.
REQ-010 SHALL have port ovf_clr  input  1  clears all ovf bits.

Function
REQ-011 SHALL keep one pending bit per button; press[i]=1 sets pending[i] on the next edge unless button i is locked out (REQ-018).
REQ-012 SHALL implement FSM states IDLE and OFFER; reset state IDLE.
REQ-013 IDLE: if any pending bit set, SHALL select the first set bit at index >= rr_ptr, wrapping modulo NUM_BTN, load it into evt_id, clear that pending bit, assert evt_valid, go to OFFER; else remain IDLE with evt_valid=0.
REQ-014 OFFER: SHALL hold evt_valid=1 and evt_id stable until a cycle with evt_ready=1; on that edge go to IDLE, deassert evt_valid, set rr_ptr = (evt_id+1) mod NUM_BTN.
REQ-015 Latency: press at edge t -> pending at t+1 -> evt_valid at t+2 when FSM idle and no other pending; minimum one IDLE cycle between consecutive events.
REQ-016 Press on button i while pending[i]=1 SHALL keep pending[i]=1 and set ovf[i]; events are not counted beyond one.
REQ-017 Press on button i in the same cycle its pending bit is cleared by selection SHALL leave pending[i]=1 (new event, no overflow).
REQ-018 On handshake SHALL record last_id=evt_id and load lockout counter with LOCKOUT; counter decrements each cycle to 0; while nonzero, press[last_id] ignored (no pending, no ovf); other buttons unaffected.
REQ-019 A new handshake while counter nonzero SHALL reload counter and replace last_id.
REQ-020 ovf_clr=1 SHALL clear all ovf bits; an overflow event in the same cycle SHALL win for its bit.
REQ-021 evt_ready while evt_valid=0 SHALL have no effect.
REQ-022 Multiple simultaneous presses SHALL all be captured in pending and served in round-robin order from rr_ptr.

Reset
REQ-023 reset=1 SHALL immediately force: FSM IDLE, evt_valid=0, evt_id=0, pending=0, ovf=0, rr_ptr=0, lockout counter=0, last_id=0.
REQ-024 Reset asserted during OFFER SHALL drop the offered event without handshake; no event replays after release.
REQ-025 First press SHALL be accepted on the first edge after reset deasserts.

Verification (NUM_BTN=4, LOCKOUT=8)
REQ-026 Single: press=0010 for 1 cycle, evt_ready=1 -> evt_valid high 2 cycles after press, evt_id=1, one event only, rr_ptr=2.
REQ-027 Round-robin: press=1111 same cycle, evt_ready=1 -> ids 0,1,2,3 in order, each valid 1 cycle separated by 1 IDLE cycle; ovf=0000.
REQ-028 Backpressure/overflow: evt_ready=0, press bit 2 twice then bit 0 -> evt_id=2 held stable, ovf=0100; raise ready -> ids 2 then 0; ovf_clr -> ovf=0000.
REQ-029 Lockout: grant id 3, press bit 3 at 3 cycles and 9 cycles after handshake -> first ignored, second produces event; press bit 1 at 3 cycles served normally.
REQ-030 Async reset: assert reset mid-OFFER between clock edges -> evt_valid=0 and pending=0 before next edge; no event after release.
REQ-031 Coincident: press bit k on the cycle bit k is selected -> second event for k follows, ovf[k]=0.
